// File: rtl/btn_pkg.sv
// Shared definitions for the button debouncer: per-button FSM states and button indices.
package btn_pkg;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    PRESS_PEND = 2'd1,
    HELD       = 2'd2,
    REL_PEND   = 2'd3
  } db_state_t;

  localparam int BTN_RIGHT = 0;
  localparam int BTN_LEFT  = 1;
  localparam int NUM_BTNS  = 2;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/debounce_ch.sv
// One button channel: 2-flop synchronizer, polarity fix, debounce FSM and optional
// auto-repeat (enabled by defining BTN_AUTOREPEAT_EN).
module debounce_ch
  import btn_pkg::*;
#(
  parameter int DB_CYCLES  = 1000000,
  parameter int RPT_DELAY  = 25000000,
  parameter int RPT_PERIOD = 5000000,
  parameter int ACTIVE_LOW = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic level,
  output logic press,
  output logic rel
);

  localparam int CNT_W = $clog2(max_int(DB_CYCLES, RPT_DELAY) + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 2);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  if (DB_CYCLES < 2 || RPT_PERIOD < 1 || RPT_PERIOD > RPT_DELAY) begin : g_bad_cfg
    $error("debounce_ch: need DB_CYCLES >= 2 and 1 <= RPT_PERIOD <= RPT_DELAY");
  end

  db_state_t        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       sync_q;
  logic [1:0]       warm_q;
  logic             press_q, press_d;
  logic             rel_q, rel_d;
  logic             s;

  // warm_q masks the reset value of the synchronizer so a button held across
  // reset is accepted with the same latency as a clean edge.
  assign s     = warm_q[1] & ((ACTIVE_LOW != 0) ? ~sync_q[1] : sync_q[1]);
  assign level = (state_q == HELD) || (state_q == REL_PEND);
  assign press = press_q;
  assign rel   = rel_q;

`ifdef BTN_AUTOREPEAT_EN
  localparam int RPT_W = $clog2(RPT_DELAY + 1);
  localparam logic [RPT_W-1:0] RPT_LAST   = RPT_W'(RPT_DELAY - 1);
  localparam logic [RPT_W-1:0] RPT_RELOAD = RPT_W'(RPT_DELAY - RPT_PERIOD);

  logic [RPT_W-1:0] rpt_q, rpt_d;
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      sync_q  <= '0;
      warm_q  <= '0;
      state_q <= IDLE;
      cnt_q   <= '0;
      press_q <= 1'b0;
      rel_q   <= 1'b0;
`ifdef BTN_AUTOREPEAT_EN
      rpt_q   <= '0;
`endif
    end else begin
      sync_q  <= {sync_q[0], raw};
      warm_q  <= {warm_q[0], 1'b1};
      state_q <= state_d;
      cnt_q   <= cnt_d;
      press_q <= press_d;
      rel_q   <= rel_d;
`ifdef BTN_AUTOREPEAT_EN
      rpt_q   <= rpt_d;
`endif
    end
  end

  // The sample that moves the FSM into a pending state counts as the first
  // stable cycle, so DB_CYCLES stable samples end on counter value DB_CYCLES-2.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    press_d = 1'b0;
    rel_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (s) begin
          state_d = PRESS_PEND;
          cnt_d   = '0;
        end
      end
      PRESS_PEND: begin
        if (!s) begin
          state_d = IDLE;
        end else if (cnt_q >= CNT_LAST) begin
          state_d = HELD;
          press_d = 1'b1;
        end else if (cnt_q != CNT_MAX) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      HELD: begin
        if (!s) begin
          state_d = REL_PEND;
          cnt_d   = '0;
        end
      end
      REL_PEND: begin
        if (s) begin
          state_d = HELD;
        end else if (cnt_q >= CNT_LAST) begin
          state_d = IDLE;
          rel_d   = 1'b1;
        end else if (cnt_q != CNT_MAX) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

`ifdef BTN_AUTOREPEAT_EN
    // Repeat timer keeps running through REL_PEND so a release bounce does not restart it.
    rpt_d = rpt_q;
    if (state_q == PRESS_PEND && state_d == HELD) begin
      rpt_d = '0;
    end else if (state_q == HELD || state_q == REL_PEND) begin
      if (state_q == HELD && rpt_q == RPT_LAST) begin
        press_d = 1'b1;
        rpt_d   = RPT_RELOAD;
      end else if (rpt_q != RPT_LAST) begin
        rpt_d = rpt_q + 1'b1;
      end
    end
`endif
  end

endmodule

// File: rtl/button_debounce.sv
// Two-button debouncer (right = bit0, left = bit1) built from two debounce_ch channels.
// Define BTN_AUTOREPEAT_EN to enable auto-repeat press pulses while a button is held.
module button_debounce
  import btn_pkg::*;
#(
  parameter int CLK_HZ     = 50000000,
  parameter int DB_CYCLES  = 1000000,
  parameter int RPT_DELAY  = 25000000,
  parameter int RPT_PERIOD = 5000000,
  parameter int ACTIVE_LOW = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] btn_raw,
  output logic [1:0] btn_level,
  output logic [1:0] btn_press,
  output logic [1:0] btn_release
);

  if (CLK_HZ < 1) begin : g_bad_clk
    $error("button_debounce: CLK_HZ must be positive");
  end

  debounce_ch #(
    .DB_CYCLES (DB_CYCLES),
    .RPT_DELAY (RPT_DELAY),
    .RPT_PERIOD(RPT_PERIOD),
    .ACTIVE_LOW(ACTIVE_LOW)
  ) u_right (
    .clk  (clk),
    .rst  (rst),
    .raw  (btn_raw[BTN_RIGHT]),
    .level(btn_level[BTN_RIGHT]),
    .press(btn_press[BTN_RIGHT]),
    .rel  (btn_release[BTN_RIGHT])
  );

  debounce_ch #(
    .DB_CYCLES (DB_CYCLES),
    .RPT_DELAY (RPT_DELAY),
    .RPT_PERIOD(RPT_PERIOD),
    .ACTIVE_LOW(ACTIVE_LOW)
  ) u_left (
    .clk  (clk),
    .rst  (rst),
    .raw  (btn_raw[BTN_LEFT]),
    .level(btn_level[BTN_LEFT]),
    .press(btn_press[BTN_LEFT]),
    .rel  (btn_release[BTN_LEFT])
  );

endmodule

// File: tb/tb_button_debounce.sv
// Self-checking bench for button_debounce (DB_CYCLES=16, RPT_DELAY=64, RPT_PERIOD=8).
// Cycle N = N-th rising edge after an input change made on a falling edge.
module tb_button_debounce;

  logic       clk;
  logic       rst;
  logic [1:0] btn_raw;
  logic [1:0] btn_level;
  logic [1:0] btn_press;
  logic [1:0] btn_release;

  int checks_total  = 0;
  int checks_passed = 0;
  int press_cnt0 = 0, press_cnt1 = 0, rel_cnt0 = 0, rel_cnt1 = 0;

  button_debounce #(
    .CLK_HZ    (50000000),
    .DB_CYCLES (16),
    .RPT_DELAY (64),
    .RPT_PERIOD(8),
    .ACTIVE_LOW(1)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .btn_raw    (btn_raw),
    .btn_level  (btn_level),
    .btn_press  (btn_press),
    .btn_release(btn_release)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pulse counters sampled shortly after each rising edge, settled before the falling edge.
  always @(posedge clk) begin
    #2;
    if (btn_press[0])   press_cnt0++;
    if (btn_press[1])   press_cnt1++;
    if (btn_release[0]) rel_cnt0++;
    if (btn_release[1]) rel_cnt1++;
  end

  typedef struct {
    logic [1:0] raw;
    int         hold;
    logic [1:0] level;
    logic [1:0] press;
    logic [1:0] rel;
    string      name;
  } vec_t;

  vec_t vecs[8];

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic apply_stimulus(input logic [1:0] raw, input int hold);
    btn_raw = raw;
    tick(hold);
  endtask

  task automatic check_output(input string name, input int act, input int exp);
    checks_total++;
    if (act !== exp)
      $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    else
      checks_passed++;
  endtask

  task automatic check_all(input string name, input logic [1:0] lvl,
                           input logic [1:0] prs, input logic [1:0] rls);
    check_output({name, ".level"},   int'(btn_level),   int'(lvl));
    check_output({name, ".press"},   int'(btn_press),   int'(prs));
    check_output({name, ".release"}, int'(btn_release), int'(rls));
  endtask

  initial begin
    int base_p0, base_p1, base_r0, base_r1;
    int exp_rpt_pulse;
    int exp_press_total;
`ifdef BTN_AUTOREPEAT_EN
    exp_rpt_pulse   = 3;
    exp_press_total = 16;
`else
    exp_rpt_pulse   = 0;
    exp_press_total = 1;
`endif

    // Clean press on the right button, hold 100 cycles, then clean release.
    vecs[0] = '{2'b11, 20, 2'b00, 2'b00, 2'b00, "idle"};
    vecs[1] = '{2'b10, 17, 2'b00, 2'b00, 2'b00, "press_c17"};
    vecs[2] = '{2'b10,  1, 2'b01, 2'b01, 2'b00, "press_c18"};
    vecs[3] = '{2'b10,  1, 2'b01, 2'b00, 2'b00, "press_c19"};
    vecs[4] = '{2'b10, 81, 2'b01, 2'b00, 2'b00, "hold_c100"};
    vecs[5] = '{2'b11, 17, 2'b01, 2'b00, 2'b00, "rel_c17"};
    vecs[6] = '{2'b11,  1, 2'b00, 2'b00, 2'b01, "rel_c18"};
    vecs[7] = '{2'b11,  1, 2'b00, 2'b00, 2'b00, "rel_c19"};

    rst     = 1'b0;
    btn_raw = 2'b11;
    tick(3);
    check_all("reset", 2'b00, 2'b00, 2'b00);
    rst = 1'b1;

    for (int i = 0; i < 8; i++) begin
      apply_stimulus(vecs[i].raw, vecs[i].hold);
      check_all(vecs[i].name, vecs[i].level, vecs[i].press, vecs[i].rel);
    end
    check_output("clean_no_left_press", press_cnt1, 0);

    // Left button bounces every 5 cycles for 40 cycles, then stays pressed.
    base_p0 = press_cnt0;
    base_p1 = press_cnt1;
    for (int k = 0; k < 8; k++)
      apply_stimulus({logic'(k % 2), 1'b1}, 5);
    apply_stimulus(2'b01, 17);
    check_all("bounce_c17", 2'b00, 2'b00, 2'b00);
    tick(1);
    check_all("bounce_c18", 2'b10, 2'b10, 2'b00);
    tick(30);
    check_output("bounce_one_press", press_cnt1 - base_p1, 1);
    check_output("bounce_no_right", press_cnt0 - base_p0, 0);

    // Release with a 10-cycle pressed glitch after 6 cycles.
    base_r1 = rel_cnt1;
    apply_stimulus(2'b11, 6);
    apply_stimulus(2'b01, 10);
    check_output("glitch_level_mid", int'(btn_level), 2);
    apply_stimulus(2'b11, 17);
    check_output("glitch_level_c17", int'(btn_level), 2);
    check_output("glitch_no_early_rel", rel_cnt1 - base_r1, 0);
    tick(1);
    check_all("glitch_rel_c18", 2'b00, 2'b00, 2'b10);
    tick(5);

    // Both buttons pressed on the same cycle.
    apply_stimulus(2'b00, 17);
    check_all("simul_c17", 2'b00, 2'b00, 2'b00);
    tick(1);
    check_all("simul_c18", 2'b11, 2'b11, 2'b00);
    tick(1);
    check_all("simul_c19", 2'b11, 2'b00, 2'b00);
    tick(5);

    // Reset while held, button kept pressed across reset.
    base_r0 = rel_cnt0;
    base_r1 = rel_cnt1;
    rst = 1'b0;
    tick(3);
    check_all("rst_hold", 2'b00, 2'b00, 2'b00);
    base_p0 = press_cnt0;
    base_p1 = press_cnt1;
    rst = 1'b1;
    tick(17);
    check_all("rst_c17", 2'b00, 2'b00, 2'b00);
    check_output("rst_no_release", (rel_cnt0 - base_r0) + (rel_cnt1 - base_r1), 0);
    tick(1);
    check_all("rst_c18", 2'b11, 2'b11, 2'b00);

    // Keep holding to 200 cycles after reset release: repeat pulses at 82, 90, ... if enabled.
    tick(63);
    check_output("rpt_c81", int'(btn_press), 0);
    tick(1);
    check_output("rpt_c82", int'(btn_press), exp_rpt_pulse);
    tick(8);
    check_output("rpt_c90", int'(btn_press), exp_rpt_pulse);
    tick(110);
    check_output("rpt_total_right", press_cnt0 - base_p0, exp_press_total);
    check_output("rpt_total_left", press_cnt1 - base_p1, exp_press_total);
    check_output("rpt_level_c200", int'(btn_level), 3);

    apply_stimulus(2'b11, 20);
    check_output("final_level", int'(btn_level), 0);

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
